// File: rtl/id_stage.sv
// Instruction-decode stage: 32x32 register file written from WB, main
// control decode, immediate sign extension and the ID/EX pipeline latch.
module id_stage #(
  parameter int          NUM_REGS  = 32,
  parameter logic [31:0] RESET_NPC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_npc,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [15:0] id_instr,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  input  logic        id_flush,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  output logic [1:0]  ex_wb,
  output logic [2:0]  ex_m,
  output logic [3:0]  ex_ex,
  output logic [31:0] ex_npc,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_sign_ext,
  output logic [4:0]  ex_instr_2016,
  output logic [4:0]  ex_instr_1511
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic [31:0] regs_q [NUM_REGS];

  logic        wb_we_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic [1:0]  ctrl_wb_s;
  logic [2:0]  ctrl_m_s;
  logic [3:0]  ctrl_ex_s;

  logic [1:0]  ex_wb_d,  ex_wb_q;
  logic [2:0]  ex_m_d,   ex_m_q;
  logic [3:0]  ex_ex_d,  ex_ex_q;
  logic [31:0] ex_npc_q;
  logic [31:0] ex_rd1_q;
  logic [31:0] ex_rd2_q;
  logic [31:0] ex_sign_ext_d, ex_sign_ext_q;
  logic [4:0]  ex_instr_2016_q;
  logic [4:0]  ex_instr_1511_q;

  // R0 is hard-wired to zero, so writes aimed at it are dropped entirely
  assign wb_we_s = wb_regwrite && (wb_write_reg != 5'd0);

  // Register file storage: cleared on reset, one WB write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (wb_we_s) begin
      regs_q[wb_write_reg] <= wb_write_data;
    end
  end

  // Combinational reads with write-before-read bypass from WB
  always_comb begin
    rd1_s = 32'd0;
    rd2_s = 32'd0;
    if (wb_we_s && (wb_write_reg == rs)) begin
      rd1_s = wb_write_data;
    end else if (rs == 5'd0) begin
      rd1_s = 32'd0;
    end else begin
      rd1_s = regs_q[rs];
    end
    if (wb_we_s && (wb_write_reg == rt)) begin
      rd2_s = wb_write_data;
    end else if (rt == 5'd0) begin
      rd2_s = 32'd0;
    end else begin
      rd2_s = regs_q[rt];
    end
  end

  // Main control decode; unknown opcodes decode to a NOP
  always_comb begin
    ctrl_ex_s = 4'b0000;
    ctrl_m_s  = 3'b000;
    ctrl_wb_s = 2'b00;
    case (opcode)
      OP_RTYPE: begin ctrl_ex_s = 4'b1100; ctrl_m_s = 3'b000; ctrl_wb_s = 2'b10; end
      OP_LW:    begin ctrl_ex_s = 4'b0001; ctrl_m_s = 3'b010; ctrl_wb_s = 2'b11; end
      OP_SW:    begin ctrl_ex_s = 4'b0001; ctrl_m_s = 3'b001; ctrl_wb_s = 2'b00; end
      OP_BEQ:   begin ctrl_ex_s = 4'b0010; ctrl_m_s = 3'b100; ctrl_wb_s = 2'b00; end
      default:  begin ctrl_ex_s = 4'b0000; ctrl_m_s = 3'b000; ctrl_wb_s = 2'b00; end
    endcase
  end

  // Next latch contents: a flush turns the control bundle into a bubble
  always_comb begin
    ex_wb_d       = 2'b00;
    ex_m_d        = 3'b000;
    ex_ex_d       = 4'b0000;
    ex_sign_ext_d = {{16{id_instr[15]}}, id_instr};
    if (id_flush) begin
      ex_wb_d = 2'b00;
      ex_m_d  = 3'b000;
      ex_ex_d = 4'b0000;
    end else begin
      ex_wb_d = ctrl_wb_s;
      ex_m_d  = ctrl_m_s;
      ex_ex_d = ctrl_ex_s;
    end
  end

  // ID/EX pipeline latch, updated every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_wb_q         <= 2'b00;
      ex_m_q          <= 3'b000;
      ex_ex_q         <= 4'b0000;
      ex_npc_q        <= RESET_NPC;
      ex_rd1_q        <= 32'd0;
      ex_rd2_q        <= 32'd0;
      ex_sign_ext_q   <= 32'd0;
      ex_instr_2016_q <= 5'd0;
      ex_instr_1511_q <= 5'd0;
    end else begin
      ex_wb_q         <= ex_wb_d;
      ex_m_q          <= ex_m_d;
      ex_ex_q         <= ex_ex_d;
      ex_npc_q        <= id_npc;
      ex_rd1_q        <= rd1_s;
      ex_rd2_q        <= rd2_s;
      ex_sign_ext_q   <= ex_sign_ext_d;
      ex_instr_2016_q <= instr_2016;
      ex_instr_1511_q <= instr_1511;
    end
  end

  assign ex_wb         = ex_wb_q;
  assign ex_m          = ex_m_q;
  assign ex_ex         = ex_ex_q;
  assign ex_npc        = ex_npc_q;
  assign ex_rd1        = ex_rd1_q;
  assign ex_rd2        = ex_rd2_q;
  assign ex_sign_ext   = ex_sign_ext_q;
  assign ex_instr_2016 = ex_instr_2016_q;
  assign ex_instr_1511 = ex_instr_1511_q;

endmodule
